multi_clock_divider: RTL



---
 rtl/clkdiv_pkg.sv | 24 ++
 rtl/clkdiv_channel.sv | 122 ++++++++++++
 rtl/multi_clock_divider.sv | 54 +++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
// Keeps the period clamp and channel-select width in one place for all users.
package clkdiv_pkg;

    localparam int DEFAULT_CNT_W = 27;
    localparam int MAX_CNT_W     = 64;
    localparam int MIN_PERIOD    = 2;

    // What a channel does on a given edge, in priority order.
    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_WRAP,
        ACT_COUNT
    } ch_action_e;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic logic [MAX_CNT_W-1:0] clamp_period(input logic [MAX_CNT_W-1:0] period);
        return (period < MAX_CNT_W'(MIN_PERIOD)) ? MAX_CNT_W'(MIN_PERIOD) : period;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/shadow configuration, pending flag
// and registered waveform/tick outputs. Shadow config takes effect only at a wrap or while idle.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W          = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(1000000),
    parameter logic [CNT_W-1:0] DEFAULT_HIGH   = CNT_W'(500000)
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_in,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] p_act_q, p_act_d;
    logic [CNT_W-1:0] h_act_q, h_act_d;
    logic [CNT_W-1:0] p_sh_q,  p_sh_d;
    logic [CNT_W-1:0] h_sh_q,  h_sh_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pending_q, pending_d;
    logic             clk_q,     clk_d;
    logic             tick_q,    tick_d;

    logic [CNT_W-1:0] p_new;
    logic [CNT_W-1:0] h_new;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cfg_period_clamped;
    ch_action_e       action;

    assign cfg_period_clamped = CNT_W'(clamp_period(MAX_CNT_W'(cfg_period)));

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        p_act_d   = p_act_q;
        h_act_d   = h_act_q;
        p_sh_d    = p_sh_q;
        h_sh_d    = h_sh_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        clk_d     = clk_q;
        tick_d    = tick_q;

        p_new   = pending_q ? p_sh_q : p_act_q;
        h_new   = pending_q ? h_sh_q : h_act_q;
        cnt_inc = cnt_q + CNT_W'(1);

        if (!en) begin
            action = ACT_IDLE;
        end else if (sync_in || (cnt_q == p_act_q - CNT_W'(1))) begin
            action = ACT_WRAP;
        end else begin
            action = ACT_COUNT;
        end

        case (action)
            ACT_IDLE: begin
                // Parking at P-1 makes the first enabled edge a wrap.
                p_act_d   = p_new;
                h_act_d   = h_new;
                pending_d = 1'b0;
                cnt_d     = p_new - CNT_W'(1);
                clk_d     = 1'b0;
                tick_d    = 1'b0;
            end
            ACT_WRAP: begin
                p_act_d   = p_new;
                h_act_d   = h_new;
                pending_d = 1'b0;
                cnt_d     = '0;
                clk_d     = (h_new != '0);
                tick_d    = 1'b1;
            end
            default: begin
                cnt_d  = cnt_inc;
                clk_d  = (cnt_inc < h_act_q);
                tick_d = 1'b0;
            end
        endcase

        // A write on a wrap edge lands after the old shadow was consumed, so it stays pending.
        if (cfg_we) begin
            p_sh_d    = cfg_period_clamped;
            h_sh_d    = cfg_high;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            p_act_q   <= DEFAULT_PERIOD;
            h_act_q   <= DEFAULT_HIGH;
            p_sh_q    <= DEFAULT_PERIOD;
            h_sh_q    <= DEFAULT_HIGH;
            cnt_q     <= DEFAULT_PERIOD - CNT_W'(1);
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            p_act_q   <= p_act_d;
            h_act_q   <= h_act_d;
            p_sh_q    <= p_sh_d;
            h_sh_q    <= h_sh_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg_pending = pending_q;
    assign clk_out     = clk_q;
    assign tick        = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Runtime-programmable multi-channel clock divider: decodes configuration writes
// to a per-channel strobe and fans sync_in out to every channel.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int               CHANNELS       = 4,
    parameter int               CNT_W          = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(1000000),
    parameter logic [CNT_W-1:0] DEFAULT_HIGH   = CNT_W'(500000),
    localparam int              CH_W           = ch_width(CHANNELS)
) (
    input  logic                clock_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync_in,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_high,
    output logic [CHANNELS-1:0] cfg_pending,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] ch_we;

    // Encodings at or above CHANNELS match no channel and are dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_HIGH   (DEFAULT_HIGH)
        ) u_ch (
            .clock_in    (clock_in),
            .rst_n       (rst_n),
            .en          (en[g]),
            .sync_in     (sync_in),
            .cfg_we      (ch_we[g]),
            .cfg_period  (cfg_period),
            .cfg_high    (cfg_high),
            .cfg_pending (cfg_pending[g]),
            .clk_out     (clk_out[g]),
            .tick        (tick[g])
        );
    end

endmodule
